// File: rtl/router_pkg.sv
// router_pkg: shared router constants, port indices and allocator state encoding.
package router_pkg;
  localparam int NPORTS = 5;
  localparam int EAST = 0;
  localparam int WEST = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;
  localparam int LOCAL = 4;
  localparam int EOP = 30;
  localparam int BOP = 29;
  typedef logic [2:0] port_t;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} alloc_state_t;
endpackage

// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request/grant bundle between input stage, allocator and crossbar.
interface switch_allocator_if #(parameter int NPORTS = router_pkg::NPORTS);
  logic [NPORTS*NPORTS-1:0] in_req;
  logic [NPORTS-1:0] in_valid;
  logic [NPORTS-1:0] in_eop;
  logic [NPORTS-1:0] out_ready;
  logic [NPORTS*NPORTS-1:0] out_grant;
  logic [NPORTS-1:0] in_grant;
  logic [NPORTS-1:0] out_busy;
  modport master (
    output in_req, in_valid, in_eop, out_ready,
    input out_grant, in_grant, out_busy
  );
  modport slave (
    input in_req, in_valid, in_eop, out_ready,
    output out_grant, in_grant, out_busy
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter: picks the first request at or after ptr (wrapping) and proposes the next pointer.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int NPORTS = router_pkg::NPORTS
) (
  input  logic [NPORTS-1:0] req,
  input  port_t             ptr,
  output logic [NPORTS-1:0] gnt,
  output logic              win,
  output port_t             idx,
  output port_t             next_ptr
);
  always_comb begin
    win = 1'b0;
    idx = '0;
    // scanning backwards leaves the first hit in round-robin order as the final assignment
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (req[port_t'((int'(ptr) + k) % NPORTS)]) begin
        win = 1'b1;
        idx = port_t'((int'(ptr) + k) % NPORTS);
      end
    end
    gnt = win ? (NPORTS'(1) << idx) : '0;
    next_ptr = !win ? ptr : (idx == port_t'(NPORTS - 1)) ? '0 : idx + 3'd1;
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: wormhole output-port allocator with per-output round-robin arbitration.
module switch_allocator
  import router_pkg::*;
#(
  parameter int NPORTS = router_pkg::NPORTS
) (
  input logic clk,
  input logic reset,
  switch_allocator_if.slave bus
);
  logic [NPORTS-1:0] low [NPORTS];
  logic [NPORTS-1:0] col [NPORTS];
  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      low[i] = bus.in_req[i*NPORTS +: NPORTS] & (~bus.in_req[i*NPORTS +: NPORTS] + NPORTS'(1));
  end
  always_comb begin
    bus.out_grant = '0;
    bus.in_grant = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++) begin
        bus.out_grant[i*NPORTS+o] = col[o][i];
        bus.in_grant[i] = bus.in_grant[i] | col[o][i];
      end
    end
  end
  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    alloc_state_t state_q, state_d;
    port_t owner_q, owner_d, ptr_q, ptr_d, idx, next_ptr;
    logic [NPORTS-1:0] cand, gnt, col_q, col_d;
    logic win, xfer;
    // an input already holding an output may not bid, so it never owns two at once
    always_comb begin
      for (int i = 0; i < NPORTS; i++) cand[i] = low[i][o] & ~bus.in_grant[i];
    end
    rr_arbiter #(.NPORTS(NPORTS)) u_arb (
      .req(cand),
      .ptr(ptr_q),
      .gnt(gnt),
      .win(win),
      .idx(idx),
      .next_ptr(next_ptr)
    );
    assign xfer = (state_q == LOCKED) && bus.in_valid[owner_q] && bus.out_ready[o];
    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      col_d = col_q;
      if (state_q == IDLE && win) begin
        state_d = LOCKED;
        owner_d = idx;
        ptr_d = next_ptr;
        col_d = gnt;
      end else if (xfer && bus.in_eop[owner_q]) begin
        state_d = IDLE;
        col_d = '0;
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        owner_q <= '0;
        ptr_q <= '0;
        col_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q <= ptr_d;
        col_q <= col_d;
      end
    end
    assign col[o] = col_q;
    assign bus.out_busy[o] = (state_q == LOCKED);
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed-vector self-checking bench for switch_allocator.
module tb_switch_allocator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [24:0] exp_g;
  switch_allocator_if #(.NPORTS(5)) bus ();
  switch_allocator dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task tick();
    @(posedge clk);
    #1;
  endtask
  task idle();
    bus.in_req = '0;
    bus.in_valid = '0;
    bus.in_eop = '0;
    bus.out_ready = '0;
  endtask
  task test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL reset_out_grant got=%h exp=%h", bus.out_grant, 25'd0); end
    total++; if (bus.in_grant !== 5'd0) begin bad++; $display("FAIL reset_in_grant got=%b exp=%b", bus.in_grant, 5'd0); end
    total++; if (bus.out_busy !== 5'd0) begin bad++; $display("FAIL reset_out_busy got=%b exp=%b", bus.out_busy, 5'd0); end
  endtask
  task test_single();
    idle();
    bus.in_req[20] = 1'b1;
    tick();
    exp_g = '0; exp_g[20] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL single_grant got=%h exp=%h", bus.out_grant, exp_g); end
    total++; if (bus.in_grant !== 5'b10000) begin bad++; $display("FAIL single_in_grant got=%b exp=%b", bus.in_grant, 5'b10000); end
    total++; if (bus.out_busy !== 5'b00001) begin bad++; $display("FAIL single_busy got=%b exp=%b", bus.out_busy, 5'b00001); end
    bus.in_req[20] = 1'b0;
    bus.in_valid[4] = 1'b1;
    bus.out_ready[0] = 1'b1;
    tick();
    tick();
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL single_hold got=%h exp=%h", bus.out_grant, exp_g); end
    bus.in_eop[4] = 1'b1;
    tick();
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL single_release got=%h exp=%h", bus.out_grant, 25'd0); end
    total++; if (dut.g_out[0].ptr_q !== 3'd0) begin bad++; $display("FAIL single_ptr got=%0d exp=%0d", dut.g_out[0].ptr_q, 0); end
    idle();
  endtask
  task test_contention();
    int w;
    idle();
    bus.in_req[8] = 1'b1;
    bus.in_req[13] = 1'b1;
    bus.in_req[18] = 1'b1;
    bus.out_ready[3] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      w = n + 1;
      tick();
      exp_g = '0; exp_g[w*5+3] = 1'b1;
      total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL contention_grant%0d got=%h exp=%h", w, bus.out_grant, exp_g); end
      bus.in_valid[w] = 1'b1;
      tick();
      total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL contention_hold%0d got=%h exp=%h", w, bus.out_grant, exp_g); end
      bus.in_eop[w] = 1'b1;
      tick();
      total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL contention_bubble%0d got=%h exp=%h", w, bus.out_grant, 25'd0); end
      bus.in_valid[w] = 1'b0;
      bus.in_eop[w] = 1'b0;
      bus.in_req[w*5+3] = 1'b0;
    end
    total++; if (dut.g_out[3].ptr_q !== 3'd4) begin bad++; $display("FAIL contention_ptr got=%0d exp=%0d", dut.g_out[3].ptr_q, 4); end
    idle();
  endtask
  task test_rr_wrap();
    idle();
    bus.in_req[8] = 1'b1;
    bus.in_req[23] = 1'b1;
    bus.out_ready[3] = 1'b1;
    tick();
    exp_g = '0; exp_g[23] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL rr_wrap_first got=%h exp=%h", bus.out_grant, exp_g); end
    bus.in_valid[4] = 1'b1;
    bus.in_eop[4] = 1'b1;
    tick();
    bus.in_req[23] = 1'b0;
    bus.in_valid[4] = 1'b0;
    bus.in_eop[4] = 1'b0;
    tick();
    exp_g = '0; exp_g[8] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL rr_wrap_second got=%h exp=%h", bus.out_grant, exp_g); end
    bus.in_req[8] = 1'b0;
    bus.in_valid[1] = 1'b1;
    bus.in_eop[1] = 1'b1;
    tick();
    idle();
  endtask
  task test_backpressure();
    idle();
    bus.in_req[2] = 1'b1;
    tick();
    exp_g = '0; exp_g[2] = 1'b1;
    bus.in_valid[0] = 1'b1;
    bus.in_eop[0] = 1'b1;
    bus.in_req[7] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL backpressure_hold%0d got=%h exp=%h", n, bus.out_grant, exp_g); end
    end
    bus.out_ready[2] = 1'b1;
    tick();
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL backpressure_release got=%h exp=%h", bus.out_grant, 25'd0); end
    bus.in_req[2] = 1'b0;
    bus.in_valid[0] = 1'b0;
    bus.in_eop[0] = 1'b0;
    tick();
    exp_g = '0; exp_g[7] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL backpressure_next got=%h exp=%h", bus.out_grant, exp_g); end
    bus.in_req[7] = 1'b0;
    bus.in_valid[1] = 1'b1;
    bus.in_eop[1] = 1'b1;
    tick();
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL backpressure_done got=%h exp=%h", bus.out_grant, 25'd0); end
    idle();
  endtask
  task test_parallel();
    idle();
    bus.in_req[2] = 1'b1;
    bus.in_req[8] = 1'b1;
    bus.in_req[14] = 1'b1;
    tick();
    exp_g = '0; exp_g[2] = 1'b1; exp_g[8] = 1'b1; exp_g[14] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL parallel_grant got=%h exp=%h", bus.out_grant, exp_g); end
    total++; if (bus.in_grant !== 5'b00111) begin bad++; $display("FAIL parallel_in_grant got=%b exp=%b", bus.in_grant, 5'b00111); end
    total++; if (bus.out_busy !== 5'b11100) begin bad++; $display("FAIL parallel_busy got=%b exp=%b", bus.out_busy, 5'b11100); end
    bus.in_req = '0;
    bus.in_valid = 5'b00111;
    bus.in_eop = 5'b00111;
    bus.out_ready = 5'b11111;
    tick();
    total++; if (bus.out_busy !== 5'b00000) begin bad++; $display("FAIL parallel_release got=%b exp=%b", bus.out_busy, 5'b00000); end
    idle();
  endtask
  task test_multihot();
    idle();
    bus.in_req[19:15] = 5'b01010;
    tick();
    exp_g = '0; exp_g[16] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL multihot_grant got=%h exp=%h", bus.out_grant, exp_g); end
    total++; if (bus.out_busy !== 5'b00010) begin bad++; $display("FAIL multihot_busy got=%b exp=%b", bus.out_busy, 5'b00010); end
    bus.in_req = '0;
    bus.in_valid[3] = 1'b1;
    bus.in_eop[3] = 1'b1;
    bus.out_ready[1] = 1'b1;
    tick();
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL multihot_release got=%h exp=%h", bus.out_grant, 25'd0); end
    idle();
  endtask
  task test_reset_mid();
    idle();
    bus.in_req[10] = 1'b1;
    tick();
    exp_g = '0; exp_g[10] = 1'b1;
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL reset_mid_lock got=%h exp=%h", bus.out_grant, exp_g); end
    reset = 1'b1;
    tick();
    total++; if (bus.out_grant !== 25'd0) begin bad++; $display("FAIL reset_mid_grant got=%h exp=%h", bus.out_grant, 25'd0); end
    total++; if (bus.out_busy !== 5'd0) begin bad++; $display("FAIL reset_mid_busy got=%b exp=%b", bus.out_busy, 5'd0); end
    total++; if (dut.g_out[0].ptr_q !== 3'd0) begin bad++; $display("FAIL reset_mid_ptr got=%0d exp=%0d", dut.g_out[0].ptr_q, 0); end
    reset = 1'b0;
    tick();
    total++; if (bus.out_grant !== exp_g) begin bad++; $display("FAIL reset_mid_regrant got=%h exp=%h", bus.out_grant, exp_g); end
    idle();
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_backpressure();
    test_parallel();
    test_multihot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Output-port allocator for the five-port virtual-channel router. It takes the one-hot port requests that each input's XY route computation produces for the header flit and grants each output port to at most one input with round-robin fairness. It holds the grant for the whole packet, wormhole style, until the tail flit has crossed the crossbar. It sits between the per-input routing/buffer stage and the crossbar select logic.

## Interface
Parameters:
- NPORTS, 5, number of router ports; index 0 east, 1 west, 2 north, 3 south, 4 local.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- in_req  in  NPORTS*NPORTS  request of input i for output o at bit i*NPORTS+o; combinational from routing, held while header waits.
- in_valid  in  NPORTS  input i has a flit at the head of its buffer.
- in_eop  in  NPORTS  head flit of input i is a tail (header bit 30).
- out_ready  in  NPORTS  downstream of output o can accept a flit this cycle (credit available).
- out_grant  out  NPORTS*NPORTS  registered; bit i*NPORTS+o set when output o is owned by input i; drives crossbar select.
- in_grant  out  NPORTS  OR of out_grant over outputs for input i; input may pop when in_grant & out_ready of its output.
- out_busy  out  NPORTS  output o is LOCKED.

## Operation
- Per output o: state IDLE or LOCKED, owner (3 bits), round-robin pointer ptr (3 bits, 0..NPORTS-1).
- Eligibility: input i is a candidate for o when in_req[i*NPORTS+o] = 1, input i is not already an owner of any output, and o is the lowest set bit in i's request vector. Multi-hot requests are honoured only at their lowest bit; the other bits are ignored.
- IDLE: the winner is the first candidate found scanning i = ptr, ptr+1, …, wrapping mod NPORTS. On a win: state becomes LOCKED, owner becomes i, ptr becomes (i+1) mod NPORTS, and the out_grant bit sets. With no candidate, the state holds.
- The same-edge conflict cannot occur. An input can win at most one output per cycle because eligibility uses only its lowest request bit.
- LOCKED: the grant stays asserted regardless of in_req. A transfer occurs when in_valid[owner] & out_ready[o].
  - Transfer with in_eop[owner] = 1: next state IDLE, grant cleared, ptr unchanged.
  - Transfer without eop: stay LOCKED.
  - No transfer: stay LOCKED. There is no timeout.
- Single-flit packets (bop & eop) never generate a request and are out of scope.
- Reset:
  - out_grant = 0, in_grant = 0, out_busy = 0.
  - All states IDLE, owners 0, ptrs 0.
  - A packet in flight when reset asserts loses its lock; no flush is performed.

## Timing
- Request sampled at edge N → out_grant / in_grant / out_busy visible after edge N+1 (1-cycle allocation latency).
- Tail transfer in cycle T → grant low in cycle T+1. The earliest new grant on that output is visible in cycle T+2, a one-cycle bubble by design.
- in_grant is a pure combinational OR of registered bits; no other comb path exists from inputs to outputs.
- All state updates occur on the rising clk edge; reset has priority over every other update.

## Structure
- Shared package router_pkg:
  - NPORTS and port index constants (EAST = 0, WEST = 1, NORTH = 2, SOUTH = 3, LOCAL = 4).
  - Allocator state encoding: IDLE = 0, LOCKED = 1.
  - Header bit positions: EOP = 30, BOP = 29.
- Sub-module rr_arbiter: one per output, NPORTS-bit request in, one-hot grant plus pointer update. It is instantiated NPORTS times inside switch_allocator. Ownership and lock state stay in the top level.

## Test plan
- Single request: input 4 (local) requests output 0 at cycle 1 → out_grant bit 20 high from cycle 2. Three flits with out_ready = 1, eop on the third → grant low in the cycle after the third transfer; ptr[0] = 0.
- Contention: inputs 1, 2 and 3 request output 3 simultaneously, ptr = 0, each sends a 2-flit packet → grants in order 1, 2, 3, each separated by exactly one idle cycle.
- Backpressure: locked output 2 with out_ready = 0 for 5 cycles → grant held and no transfer counted. A new request from another input for output 2 stays ungranted until the tail passes.
- Parallel outputs: in the same cycle, input 0 → output 2, input 1 → output 3, input 2 → output 4 → all three grants are visible on the same following cycle.
- Multi-hot request: input 3 has in_req = 5'b01010 → only output 1 is granted; output 3 stays IDLE.
- Reset mid-packet: reset while output 0 is locked to input 2 → the next cycle shows all grants 0, out_busy = 0 and ptrs 0. A re-asserted request is granted 1 cycle after reset deasserts.
